risc_ctrl_seq: RTL and testbench
================================

// Module: risc_ctrl_seq
// PURPOSE
//  8-phase control sequencer for the 8-bit RISC processor. Each instruction takes 8 phases.
//  Drives fch to the PC/IR address mux (fch=1: memory address from PC; fch=0: from IR operand).
//  Also drives memory rd/wr, IR/AC/PC load strobes, PC increment, data-bus enable and halt.
//  Sits upstream of the address mux; takes the opcode from the IR and the zero flag from the ALU/AC.
// PARAMETERS
//  OPW        3   opcode width (IR[7:5]); only 3 is supported
//  RST_PHASE  0   phase entered at reset (0..7); the default is the only value used in the CPU
// PORTS
//  clk      in   1    system clock, rising edge
//  rst_n    in   1    asynchronous reset, active-low
//  en       in   1    1 = advance one phase per clk; 0 = freeze phase and every output
//  opcode   in   3    IR opcode field; sampled only at the end of phase 3
//  zero     in   1    accumulator == 0; sampled live in phase 6
//  phase    out  3    current phase 0..7
//  fch      out  1    address-mux select: 1 = PC, 0 = IR operand
//  rd       out  1    memory read enable
//  wr       out  1    memory write enable
//  ld_ir    out  1    load instruction register
//  ld_ac    out  1    load accumulator
//  ld_pc    out  1    load PC from the IR operand (JMP)
//  inc_pc   out  1    PC += 1
//  data_e   out  1    drive the accumulator onto the data bus (STO)
//  halt     out  1    sticky halt indicator
// BEHAVIOUR
//  - Reset (async, rst_n=0): phase=RST_PHASE, op_q=HLT-free NOP (ADD encoding masked), halt=0.
//    All strobes read 0 except fch=1 and rd=0 (phase-0 decode). Release takes effect at the next clk edge.
//  - Phase register: 3-bit, increments by 1 per clk when en=1 and halt=0, wraps 7->0.
//    With en=0 or halt=1, the phase holds.
//  - op_q: opcode is registered at the clk edge leaving phase 3. Phases 4-7 decode only op_q.
//  - Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
//    ALUOP = ADD | AND | XOR | LDA.
//  - Outputs are combinational decodes of (phase, op_q, zero, halt); no extra latency.
//    Per-phase decode (unlisted strobes = 0):
//    - 0 INST_ADDR:  fch=1
//    - 1 INST_FETCH: fch=1, rd=1
//    - 2 INST_LOAD:  fch=1, rd=1, ld_ir=1
//    - 3 IDLE:       fch=1, rd=1, ld_ir=1
//    - 4 OP_ADDR:    fch=0, inc_pc=1 (not asserted if op_q==HLT)
//    - 5 OP_FETCH:   fch=0, rd=ALUOP
//    - 6 ALU_OP:     fch=0, rd=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO
//    - 7 STORE:      fch=0, rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO
//  - HLT: halt sets at the clk edge leaving phase 4 when op_q==HLT. The phase then sticks at 5.
//    All strobes are forced to 0 and fch to 0 while halted. Only rst_n clears halt.
//  - wr and rd are never both 1. A bench assertion covers this.
//  - en low mid-instruction: the phase, op_q and outputs are held exactly. Resuming continues the same phase.
//  - rst_n asserted mid-instruction: immediate return to the reset state. A partial store is abandoned;
//    wr drops combinationally with the phase.
// STRUCTURE
//  - Shared package risc_pkg: opcode localparams (OP_HLT..OP_JMP) and phase encodings (PH_INST_ADDR..PH_STORE).
//    These are reused by the IR, ALU and TB.
//  - One natural sub-module: risc_op_dec (op_q -> is_aluop/is_skz/is_jmp/is_sto/is_hlt).
//  - Phase counter, op_q/halt registers and output decode stay in the top module.
// TESTING
//  - Reset: rst_n=0 mid-phase 6 with op STO -> phase=0, fch=1, wr=0 and data_e=0 immediately (no clk).
//  - ADD (op 2), en=1: 8 clks -> rd high in phases 1-3 and 5-7, ld_ac only in phase 7, inc_pc only in phase 4,
//    fch=1 in phases 0-3 and 0 in phases 4-7.
//  - SKZ (op 1): zero=1 -> inc_pc in phases 4 and 6; zero=0 -> inc_pc in phase 4 only.
//  - STO (op 6) then JMP (op 7): STO -> wr=1 only in phase 7, data_e in phases 6-7.
//    JMP -> ld_pc in phases 6-7, no rd in phases 5-7.
//  - HLT (op 0): halt=1 after the phase-4 edge. phase stays 5 for 20 clks with all strobes 0.
//    Clears only on rst_n.
//  - Stall: en=0 for 3 clks in phase 2 -> phase, ld_ir and rd held. Opcode changed during the stall,
//    before phase 3 -> the new value is captured in op_q.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared opcode and phase encodings for the 8-bit RISC core (IR, ALU, sequencer, TB).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package risc_pkg;

  // Opcode field IR[7:5]
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Eight phases per instruction: 0-3 fetch, 4-7 execute
  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Control strobe bundle driven by the sequencer
  typedef struct packed {
    logic fch;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic data_e;
  } ctrl_t;

endpackage

// File: rtl/risc_op_dec.sv
// Opcode class decode for the execute phases.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its input.
module risc_op_dec
  import risc_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] op,
  output logic           is_aluop,
  output logic           is_skz,
  output logic           is_jmp,
  output logic           is_sto,
  output logic           is_hlt
);

  // Classify the registered opcode; ALU-class ops all read memory and load AC
  always_comb begin
    is_aluop = 1'b0;
    is_skz   = 1'b0;
    is_jmp   = 1'b0;
    is_sto   = 1'b0;
    is_hlt   = 1'b0;
    case (op)
      OP_HLT:                         is_hlt   = 1'b1;
      OP_SKZ:                         is_skz   = 1'b1;
      OP_ADD, OP_AND, OP_XOR, OP_LDA: is_aluop = 1'b1;
      OP_STO:                         is_sto   = 1'b1;
      OP_JMP:                         is_jmp   = 1'b1;
      default:                        is_aluop = 1'b0;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_seq.sv
// 8-phase control sequencer: phase counter, opcode latch, sticky halt and strobe decode.
// Latency: strobes are a combinational decode of the current phase; one phase per enabled clk.
// Backpressure: en=0 freezes phase, op_q and all outputs; halt freezes the phase at 5 until reset.
module risc_ctrl_seq
  import risc_pkg::*;
#(
  parameter int          OPW       = 3,
  parameter logic [2:0]  RST_PHASE = 3'd0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic [2:0]     phase,
  output logic           fch,
  output logic           rd,
  output logic           wr,
  output logic           ld_ir,
  output logic           ld_ac,
  output logic           ld_pc,
  output logic           inc_pc,
  output logic           data_e,
  output logic           halt
);

  phase_e         phase_q, phase_d;
  logic [OPW-1:0] op_q, op_d;
  logic           halt_q, halt_d;
  ctrl_t          ctl;

  logic is_aluop, is_skz, is_jmp, is_sto, is_hlt;

  risc_op_dec #(.OPW(OPW)) u_dec (
    .op       (op_q),
    .is_aluop (is_aluop),
    .is_skz   (is_skz),
    .is_jmp   (is_jmp),
    .is_sto   (is_sto),
    .is_hlt   (is_hlt)
  );

  // State registers; reset leaves op_q on a non-HLT encoding so no spurious halt can occur
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= phase_e'(RST_PHASE);
      op_q    <= OPW'(OP_ADD);
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      op_q    <= op_d;
      halt_q  <= halt_d;
    end
  end

  // Next-state and strobe decode; halted state forces every strobe (including fch) low
  always_comb begin
    phase_d = phase_q;
    op_d    = op_q;
    halt_d  = halt_q;
    ctl     = '0;

    if (en && !halt_q) begin
      phase_d = phase_e'(phase_q + 3'd1);
      // Opcode is captured on the edge leaving IDLE, after ld_ir has settled the IR
      if (phase_q == PH_IDLE) begin
        op_d = opcode;
      end
      // HLT takes effect leaving OP_ADDR, so the phase parks at OP_FETCH
      if (phase_q == PH_OP_ADDR && is_hlt) begin
        halt_d = 1'b1;
      end
    end

    if (!halt_q) begin
      case (phase_q)
        PH_INST_ADDR: begin
          ctl.fch = 1'b1;
        end
        PH_INST_FETCH: begin
          ctl.fch = 1'b1;
          ctl.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          ctl.fch   = 1'b1;
          ctl.rd    = 1'b1;
          ctl.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          ctl.inc_pc = !is_hlt;
        end
        PH_OP_FETCH: begin
          ctl.rd = is_aluop;
        end
        PH_ALU_OP: begin
          ctl.rd     = is_aluop;
          ctl.inc_pc = is_skz & zero;
          ctl.ld_pc  = is_jmp;
          ctl.data_e = is_sto;
        end
        PH_STORE: begin
          ctl.rd     = is_aluop;
          ctl.ld_ac  = is_aluop;
          ctl.ld_pc  = is_jmp;
          ctl.wr     = is_sto;
          ctl.data_e = is_sto;
        end
        default: ctl = '0;
      endcase
    end
  end

  assign phase  = phase_q;
  assign fch    = ctl.fch;
  assign rd     = ctl.rd;
  assign wr     = ctl.wr;
  assign ld_ir  = ctl.ld_ir;
  assign ld_ac  = ctl.ld_ac;
  assign ld_pc  = ctl.ld_pc;
  assign inc_pc = ctl.inc_pc;
  assign data_e = ctl.data_e;
  assign halt   = halt_q;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Directed bench for the 8-phase sequencer with immediate-assertion checks.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: exercises en stalls and the sticky halt.
module tb_risc_ctrl_seq;
  import risc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       fch, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;

  int total = 0;
  int bad   = 0;

  // Strobe vector {fch,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt}
  logic [8:0] st;
  assign st = {fch, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

  localparam logic [8:0] S_PH0  = 9'h100;  // fch
  localparam logic [8:0] S_PH1  = 9'h180;  // fch rd
  localparam logic [8:0] S_PH23 = 9'h1A0;  // fch rd ld_ir

  risc_ctrl_seq #(.OPW(3), .RST_PHASE(3'd0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .fch    (fch),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .data_e (data_e),
    .halt   (halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // rd and wr must never be asserted together
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!(rd && wr)) else begin
        bad++;
        $error("FAIL rd_wr_excl observed rd=%b wr=%b expected not both 1", rd, wr);
      end
    end
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Check current phase and strobes, then move to the next sample point
  task automatic step_chk(input string tag, input logic [2:0] ph, input logic [8:0] s);
    chk($sformatf("%s_p%0d_phase", tag, ph), {6'b0, phase}, {6'b0, ph});
    chk($sformatf("%s_p%0d_strobe", tag, ph), st, s);
    adv();
  endtask

  // Full instruction: fetch phases are opcode-independent; tail = expected strobes for phases 4..7
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [35:0] tail);
    opcode = op;
    zero   = z;
    step_chk(tag, 3'd0, S_PH0);
    step_chk(tag, 3'd1, S_PH1);
    step_chk(tag, 3'd2, S_PH23);
    step_chk(tag, 3'd3, S_PH23);
    for (int i = 0; i < 4; i++) begin
      step_chk(tag, 3'(4 + i), tail[35 - 9*i -: 9]);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    opcode = OP_HLT;
    zero   = 1'b0;

    // Reset state before any clock
    #2;
    chk("reset_phase", {6'b0, phase}, 9'd0);
    chk("reset_strobe", st, S_PH0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // ADD: rd in 5-7, ld_ac in 7, inc_pc in 4; zero=1 must not matter
    run_instr("add", OP_ADD, 1'b1, {9'h004, 9'h080, 9'h080, 9'h090});
    // SKZ with zero=1 and zero=0
    run_instr("skz1", OP_SKZ, 1'b1, {9'h004, 9'h000, 9'h004, 9'h000});
    run_instr("skz0", OP_SKZ, 1'b0, {9'h004, 9'h000, 9'h000, 9'h000});
    // STO then JMP
    run_instr("sto", OP_STO, 1'b0, {9'h004, 9'h000, 9'h002, 9'h042});
    run_instr("jmp", OP_JMP, 1'b0, {9'h004, 9'h000, 9'h008, 9'h008});
    // LDA behaves as ALU class
    run_instr("lda", OP_LDA, 1'b0, {9'h004, 9'h080, 9'h080, 9'h090});

    // Stall in phase 2; opcode changes from ADD to STO during the stall
    opcode = OP_ADD;
    step_chk("stall", 3'd0, S_PH0);
    step_chk("stall", 3'd1, S_PH1);
    chk("stall_enter_phase", {6'b0, phase}, 9'd2);
    en     = 1'b0;
    opcode = OP_STO;
    for (int i = 0; i < 3; i++) begin
      adv();
      chk("stall_hold_phase", {6'b0, phase}, 9'd2);
      chk("stall_hold_strobe", st, S_PH23);
    end
    en = 1'b1;
    adv();
    step_chk("stall", 3'd3, S_PH23);
    step_chk("stall", 3'd4, 9'h004);
    step_chk("stall", 3'd5, 9'h000);
    step_chk("stall", 3'd6, 9'h002);
    step_chk("stall", 3'd7, 9'h042);

    // Reset mid-STO in phase 6: immediate return to phase 0, no clock needed
    opcode = OP_STO;
    for (int p = 0; p < 6; p++) begin
      adv();
    end
    chk("rstmid_pre_phase", {6'b0, phase}, 9'd6);
    chk("rstmid_pre_strobe", st, 9'h002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_phase", {6'b0, phase}, 9'd0);
    chk("rstmid_strobe", st, S_PH0);
    #1;
    rst_n = 1'b1;

    // HLT: no inc_pc in phase 4, then parked at phase 5 with only halt high
    opcode = OP_HLT;
    step_chk("hlt", 3'd0, S_PH0);
    step_chk("hlt", 3'd1, S_PH1);
    step_chk("hlt", 3'd2, S_PH23);
    step_chk("hlt", 3'd3, S_PH23);
    opcode = OP_ADD;  // op_q already holds HLT; late IR changes must not matter
    step_chk("hlt", 3'd4, 9'h000);
    for (int i = 0; i < 20; i++) begin
      chk("hlt_park_phase", {6'b0, phase}, 9'd5);
      chk("hlt_park_strobe", st, 9'h001);
      adv();
    end

    // Only reset leaves halt
    #2;
    rst_n = 1'b0;
    #1;
    chk("hlt_rst_phase", {6'b0, phase}, 9'd0);
    chk("hlt_rst_strobe", st, S_PH0);
    #1;
    rst_n = 1'b1;
    run_instr("post_hlt_add", OP_ADD, 1'b0, {9'h004, 9'h080, 9'h080, 9'h090});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
